servo_motion_sequencer: RTL and testbench

Controller placed in front of `PWM_SERVO_CONTROL`. It accepts per-servo target angles over a valid/ready command port and slews four current angles toward their targets at a bounded rate of degrees per 20 ms frame. It drives `angle1..angle4` and issues the one-cycle `nextangle` load pulse, once per frame and only when a new value must be loaded. This keeps all four servos moving smoothly without glitching the PWM counters.

---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_slew_axis.sv | 60 ++++++
 rtl/servo_motion_sequencer.sv | 115 +++++++++++
 tb/tb_servo_motion_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion sequencer.
package servo_pkg;

   localparam int unsigned SERVO_COUNT = 4;
   localparam int unsigned MAX_ANGLE   = 180;
   localparam int unsigned ANGLE_W     = 8;
   localparam int unsigned SERVO_IDX_W = 2;

   typedef logic [ANGLE_W-1:0] angle_t;

   typedef enum logic [1:0] {
      IDLE,
      UPDATE,
      LOAD
   } seq_state_t;

   typedef struct packed {
      logic [SERVO_IDX_W-1:0] servo;
      angle_t                 angle;
   } servo_cmd_t;

   function automatic angle_t clamp_angle(input angle_t a);
      return (a > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : a;
   endfunction

endpackage

// File: rtl/servo_slew_axis.sv
// One servo axis: clamped target register and a current angle that slews
// toward it by at most STEP_DEG on each update strobe.
module servo_slew_axis
   import servo_pkg::*;
#(
   parameter int unsigned STEP_DEG   = 1,
   parameter int unsigned INIT_ANGLE = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       update,
   input  logic       wr_en,
   input  logic [7:0] wr_angle,
   output logic [7:0] current,
   output logic       changed,
   output logic       moving
);

   localparam logic [8:0] STEP_MAG = 9'(STEP_DEG);
   localparam angle_t     INIT_VAL = angle_t'(INIT_ANGLE);

   angle_t            target_q;
   angle_t            current_q;
   angle_t            current_d;
   logic signed [8:0] diff_c;
   logic        [8:0] mag_c;
   logic        [8:0] step_c;

   // Bounded step toward the target; never overshoots because step <= |diff|.
   always_comb begin
      diff_c    = $signed({1'b0, target_q}) - $signed({1'b0, current_q});
      mag_c     = diff_c[8] ? 9'(-diff_c) : 9'(diff_c);
      step_c    = (mag_c < STEP_MAG) ? mag_c : STEP_MAG;
      current_d = current_q;
      if (diff_c > 0) begin
         current_d = current_q + 8'(step_c);
      end else if (diff_c < 0) begin
         current_d = current_q - 8'(step_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_q  <= INIT_VAL;
         current_q <= INIT_VAL;
      end else begin
         if (update) begin
            current_q <= current_d;
         end
         if (wr_en) begin
            target_q <= clamp_angle(wr_angle);
         end
      end
   end

   assign current = current_q;
   assign moving  = (diff_c != 9'sd0);
   assign changed = update && moving;

endmodule

// File: rtl/servo_motion_sequencer.sv
// Frame-paced slew controller feeding four angles and a load strobe to the
// PWM servo block.
module servo_motion_sequencer
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = 1000000,
   parameter int unsigned STEP_DEG     = 1,
   parameter int unsigned INIT_ANGLE   = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_servo,
   input  logic [7:0] cmd_angle,
   output logic [7:0] angle1,
   output logic [7:0] angle2,
   output logic [7:0] angle3,
   output logic [7:0] angle4,
   output logic       nextangle,
   output logic       busy
);

   localparam int unsigned     CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   logic [CNT_W-1:0]       cnt_q;
   logic                   tick_c;
   seq_state_t             state_q;
   logic                   load_pending_q;
   logic                   nextangle_q;
   logic                   cmd_ready_q;
   logic                   cmd_fire_c;
   logic                   update_c;
   servo_cmd_t             cmd_c;
   angle_t                 cur_c     [SERVO_COUNT];
   logic [SERVO_COUNT-1:0] changed_c;
   logic [SERVO_COUNT-1:0] moving_c;

   assign tick_c     = (cnt_q == CNT_LAST);
   assign cmd_c      = '{servo: cmd_servo, angle: cmd_angle};
   assign cmd_fire_c = cmd_valid && cmd_ready_q;
   // Angles step on the edge entering UPDATE so they settle a cycle before LOAD.
   assign update_c   = (state_q == IDLE) && tick_c;

   // Free-running frame counter, independent of the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < SERVO_COUNT; g++) begin : g_axis
      servo_slew_axis #(
         .STEP_DEG   (STEP_DEG),
         .INIT_ANGLE (INIT_ANGLE)
      ) u_axis (
         .clk      (clk),
         .rst      (rst),
         .update   (update_c),
         .wr_en    (cmd_fire_c && (cmd_c.servo == SERVO_IDX_W'(g))),
         .wr_angle (cmd_c.angle),
         .current  (cur_c[g]),
         .changed  (changed_c[g]),
         .moving   (moving_c[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         load_pending_q <= 1'b1;
         nextangle_q    <= 1'b0;
         cmd_ready_q    <= 1'b0;
      end else begin
         nextangle_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick_c) begin
                  state_q     <= UPDATE;
                  cmd_ready_q <= 1'b0;
                  if (|changed_c) begin
                     load_pending_q <= 1'b1;
                  end
               end
            end
            UPDATE: begin
               if (load_pending_q) begin
                  state_q     <= LOAD;
                  nextangle_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               state_q        <= IDLE;
               load_pending_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign nextangle = nextangle_q;
   assign busy      = |moving_c;
   assign angle1    = cur_c[0];
   assign angle2    = cur_c[1];
   assign angle3    = cur_c[2];
   assign angle4    = cur_c[3];

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: three instances (STEP_DEG 1, 2, 180) share
// one command stream and are checked against a per-frame arithmetic model.
module tb_servo_motion_sequencer;

   localparam int F  = 100;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_servo;
   logic [7:0] cmd_angle;
   logic       ready [NI];
   logic       nxt   [NI];
   logic       bsy   [NI];
   logic [7:0] ang   [NI][4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      servo_motion_sequencer #(
         .FRAME_CYCLES (F),
         .STEP_DEG     ((g == 0) ? 1 : ((g == 1) ? 2 : 180)),
         .INIT_ANGLE   (90)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .cmd_valid (cmd_valid),
         .cmd_ready (ready[g]),
         .cmd_servo (cmd_servo),
         .cmd_angle (cmd_angle),
         .angle1    (ang[g][0]),
         .angle2    (ang[g][1]),
         .angle3    (ang[g][2]),
         .angle4    (ang[g][3]),
         .nextangle (nxt[g]),
         .busy      (bsy[g])
      );
   end

   int steps [NI] = '{1, 2, 180};
   int cur   [NI][4];
   int tgt   [NI][4];
   bit pend  [NI];
   bit exp_nxt [NI];
   int pulses  [NI];
   int first_k [NI];
   bit exp_ready;
   int k;
   int compares = 0;
   int fails    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Move at most s degrees from c toward t.
   function automatic int stepf(input int c, input int t, input int s);
      int d;
      d = t - c;
      if (d > 0) return c + ((d < s) ? d : s);
      if (d < 0) return c - ((-d < s) ? -d : s);
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int s = 0; s < 4; s++) begin
            cur[i][s] = 90;
            tgt[i][s] = 90;
         end
         pend[i]    = 1'b1;
         exp_nxt[i] = 1'b0;
         pulses[i]  = 0;
         first_k[i] = -1;
      end
      exp_ready = 1'b0;
      k = 0;
   endtask

   task automatic check_all();
      bit b;
      for (int i = 0; i < NI; i++) begin
         b = 1'b0;
         for (int s = 0; s < 4; s++) begin
            chk($sformatf("i%0d_angle%0d_k%0d", i, s + 1, k), 32'(ang[i][s]), 32'(cur[i][s]));
            if (cur[i][s] != tgt[i][s]) b = 1'b1;
         end
         chk($sformatf("i%0d_nextangle_k%0d", i, k), 32'(nxt[i]), 32'(exp_nxt[i]));
         chk($sformatf("i%0d_cmd_ready_k%0d", i, k), 32'(ready[i]), 32'(exp_ready));
         chk($sformatf("i%0d_busy_k%0d", i, k), 32'(bsy[i]), 32'(b));
      end
   endtask

   // One clock: advance the model by the edge, then compare all outputs.
   task automatic step();
      bit acc;
      int nv;
      acc = cmd_valid && exp_ready;
      @(posedge clk);
      k++;
      if (k % F == 0) begin
         for (int i = 0; i < NI; i++) begin
            for (int s = 0; s < 4; s++) begin
               nv = stepf(cur[i][s], tgt[i][s], steps[i]);
               if (nv != cur[i][s]) pend[i] = 1'b1;
               cur[i][s] = nv;
            end
         end
      end
      if (acc) begin
         for (int i = 0; i < NI; i++) begin
            tgt[i][cmd_servo] = (cmd_angle > 8'd180) ? 180 : int'(cmd_angle);
         end
      end
      for (int i = 0; i < NI; i++) begin
         exp_nxt[i] = 1'b0;
         if (k > F && k % F == 1 && pend[i]) begin
            exp_nxt[i] = 1'b1;
            pend[i]    = 1'b0;
         end
      end
      exp_ready = (k % F != 0);
      #1;
      check_all();
      for (int i = 0; i < NI; i++) begin
         if (nxt[i] === 1'b1) begin
            pulses[i]++;
            if (first_k[i] < 0) first_k[i] = k;
         end
      end
   endtask

   task automatic run_until(input int t);
      while (k < t) step();
   endtask

   task automatic send(input int servo, input int angle);
      cmd_valid = 1'b1;
      cmd_servo = 2'(servo);
      cmd_angle = 8'(angle);
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_servo = 2'd0;
      cmd_angle = 8'd0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      model_reset();
      check_all();

      // Idle after reset: one load pulse at cycle 101, nothing else.
      run_until(300);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("i%0d_idle_pulses", i), 32'(pulses[i]), 32'd1);
         chk($sformatf("i%0d_idle_first_pulse_k", i), 32'(first_k[i]), 32'd101);
      end

      // k=300 is an UPDATE cycle: held command waits one cycle, applies next frame.
      chk("update_cycle_ready", 32'(ready[0]), 32'd0);
      cmd_valid = 1'b1;
      cmd_servo = 2'd0;
      cmd_angle = 8'd95;
      step();
      chk("ready_after_update", 32'(ready[0]), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("no_motion_same_frame", 32'(ang[1][0]), 32'd90);
      for (int i = 0; i < NI; i++) pulses[i] = 0;
      run_until(401);
      chk("step2_frame1", 32'(ang[1][0]), 32'd92);
      chk("step2_frame1_pulse", 32'(nxt[1]), 32'd1);
      run_until(501);
      chk("step2_frame2", 32'(ang[1][0]), 32'd94);
      run_until(600);
      chk("step2_frame3", 32'(ang[1][0]), 32'd95);
      chk("step2_busy_fell", 32'(bsy[1]), 32'd0);
      run_until(699);
      chk("step2_pulses", 32'(pulses[1]), 32'd3);
      chk("step2_other_angle", 32'(ang[1][3]), 32'd90);

      // Over-range command clamps to 180.
      run_until(701);
      send(3, 200);
      run_until(801);
      chk("clamp_step180", 32'(ang[2][3]), 32'd180);

      // Later command in the same frame wins.
      send(1, 0);
      send(1, 100);
      run_until(901);
      chk("overwrite_step1", 32'(ang[0][1]), 32'd91);

      // Ramp servo 2 toward 170 and reset during the LOAD cycle at 120.
      send(2, 170);
      run_until(3901);
      chk("ramp_reached_120", 32'(ang[0][2]), 32'd120);
      chk("ramp_load_pulse", 32'(nxt[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all();
      run_until(300);
      chk("post_reset_pulses", 32'(pulses[0]), 32'd1);
      chk("post_reset_first_k", 32'(first_k[0]), 32'd101);

      // Random command traffic for twenty frames.
      for (int n = 0; n < 20 * F; n++) begin
         cmd_valid = ($urandom_range(0, 9) == 0);
         cmd_servo = 2'($urandom_range(0, 3));
         cmd_angle = 8'($urandom_range(0, 255));
         step();
      end
      cmd_valid = 1'b0;
      run_until(k + 2 * F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
